// File: rtl/wave_prof_if.sv
// Control inputs and profile write port of wave_prof_gen, with master (driver) and slave (generator) views.
// The scroll field exists only when WAVE_PROF_SCROLL_EN is defined.
interface wave_prof_if #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned VAL_W = 10
);
    logic [1:0]       mode;
    logic [VAL_W-1:0] level;
    logic [VAL_W-1:0] amp;
    logic [3:0]       period_log2;
    logic             start;
`ifdef WAVE_PROF_SCROLL_EN
    logic [IDX_W-1:0] scroll;
`endif
    logic             wave_we;
    logic [IDX_W-1:0] wave_index;
    logic [VAL_W-1:0] wave_prof;
    logic             busy;
    logic             done;

`ifdef WAVE_PROF_SCROLL_EN
    modport master (
        output mode, level, amp, period_log2, start, scroll,
        input  wave_we, wave_index, wave_prof, busy, done
    );
    modport slave (
        input  mode, level, amp, period_log2, start, scroll,
        output wave_we, wave_index, wave_prof, busy, done
    );
`else
    modport master (
        output mode, level, amp, period_log2, start,
        input  wave_we, wave_index, wave_prof, busy, done
    );
    modport slave (
        input  mode, level, amp, period_log2, start,
        output wave_we, wave_index, wave_prof, busy, done
    );
`endif
endinterface

// File: rtl/wave_prof_gen.sv
// Waveform-profile sequencer: streams DEPTH saturated flat/ramp/triangle/square entries into the profile memory.
// Optional WAVE_PROF_SCROLL_EN adds a captured scroll offset applied to the write index.
module wave_prof_gen #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10,
    parameter int unsigned VAL_W = 10,
    parameter int unsigned VMAX  = 767
) (
    input  logic        clock,
    input  logic        reset,
    wave_prof_if.slave  bus
);
    localparam int unsigned      ACC_W  = VAL_W + IDX_W + 1;
    localparam logic [ACC_W-1:0] VMAX_A = ACC_W'(VMAX);
    localparam logic [IDX_W-1:0] LAST_N = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       P_MAX  = 4'(IDX_W - 1);

    typedef enum logic {IDLE, FILL} state_t;

    typedef struct packed {
        logic [1:0]       mode;
        logic [VAL_W-1:0] level;
        logic [VAL_W-1:0] amp;
        logic [3:0]       p;
`ifdef WAVE_PROF_SCROLL_EN
        logic [IDX_W-1:0] scroll;
`endif
    } shadow_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    shadow_t          sh_q, sh_d;
    logic [ACC_W-1:0] tri_q, tri_d;
    logic [1:0]       prev_mode_q, prev_mode_d;
    logic             pending_q, pending_d;
    logic             last_q, last_d;
    logic             we_q, we_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [VAL_W-1:0] prof_q, prof_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             trigger;
    logic [IDX_W-1:0] n_shift;
    logic [ACC_W-1:0] lvl, amp_a, tri_up, raw;

    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W-1:0] x);
        return (x > VMAX_A) ? VMAX_A : x;
    endfunction

    assign bus.wave_we    = we_q;
    assign bus.wave_index = index_q;
    assign bus.wave_prof  = prof_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // Next-state, datapath and output computation
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        sh_d        = sh_q;
        tri_d       = tri_q;
        prev_mode_d = bus.mode;
        pending_d   = pending_q;
        last_d      = 1'b0;
        we_d        = 1'b0;
        busy_d      = 1'b0;
        done_d      = last_q;
        index_d     = index_q;
        prof_d      = prof_q;

        trigger = bus.start | (bus.mode != prev_mode_q) | pending_q;
        n_shift = n_q >> sh_q.p;
        lvl     = ACC_W'(sh_q.level);
        amp_a   = ACC_W'(sh_q.amp);
        tri_up  = tri_q + amp_a;

        case (sh_q.mode)
            2'd1:    raw = lvl + ACC_W'(n_q) * amp_a;
            2'd2:    raw = tri_q;
            2'd3:    raw = n_shift[0] ? (lvl + amp_a) : lvl;
            default: raw = lvl;
        endcase

        case (state_q)
            FILL: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
`ifdef WAVE_PROF_SCROLL_EN
                index_d = n_q + sh_q.scroll;
`else
                index_d = n_q;
`endif
                prof_d = VAL_W'(sat(raw));
                // Triangle runs upward in even half-periods, clamping at each rail until the flip
                tri_d  = n_shift[0] ? ((tri_q < amp_a) ? '0 : (tri_q - amp_a)) : sat(tri_up);
                n_d    = n_q + IDX_W'(1);
                if (n_q == LAST_N) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // A trigger restarts from entry 0 even mid-fill; the entry on this edge is still written
        if (trigger) begin
            state_d    = FILL;
            n_d        = '0;
            pending_d  = 1'b0;
            last_d     = 1'b0;
            sh_d.mode  = bus.mode;
            sh_d.level = bus.level;
            sh_d.amp   = bus.amp;
            sh_d.p     = (bus.period_log2 > P_MAX) ? P_MAX : bus.period_log2;
`ifdef WAVE_PROF_SCROLL_EN
            sh_d.scroll = bus.scroll;
`endif
            tri_d      = sat(ACC_W'(bus.level));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            sh_q        <= '0;
            tri_q       <= '0;
            prev_mode_q <= '0;
            pending_q   <= 1'b1;
            last_q      <= 1'b0;
            we_q        <= 1'b0;
            index_q     <= '0;
            prof_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            tri_q       <= tri_d;
            prev_mode_q <= prev_mode_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            we_q        <= we_d;
            index_q     <= index_d;
            prof_q      <= prof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_wave_prof_gen.sv
// Directed bench for wave_prof_gen: table of per-entry expectations plus hand-written abort/restart/reset sequences.
module tb_wave_prof_gen;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned VAL_W = 10;
    localparam int unsigned VMAX  = 767;

    logic clock = 1'b0;
    logic reset;

    wave_prof_if #(.IDX_W(IDX_W), .VAL_W(VAL_W)) bus ();

    wave_prof_gen #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .VAL_W(VAL_W), .VMAX(VMAX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mode;
        int         level;
        int         amp;
        int         period;
        int         pos;
        int         exp_val;
    } vec_t;

    vec_t vecs [$];
    int   tests = 0;
    int   fails = 0;
    int   seq_idx [2048];
    int   seq_val [2048];
    int   nw;
    int   done_at;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic [1:0] m, input int lv, input int am, input int p,
                       input int pos, input int ev);
        vec_t v;
        v.mode = m; v.level = lv; v.amp = am; v.period = p; v.pos = pos; v.exp_val = ev;
        vecs.push_back(v);
    endtask

    task automatic launch(input logic [1:0] m, input int lv, input int am, input int p);
        bus.mode        = m;
        bus.level       = VAL_W'(lv);
        bus.amp         = VAL_W'(am);
        bus.period_log2 = 4'(p);
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    // Record writes in order until done or the cycle budget runs out
    task automatic run_capture(input int budget);
        for (int k = 0; k < 2048; k++) begin
            seq_idx[k] = -1;
            seq_val[k] = -1;
        end
        nw      = 0;
        done_at = -1;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (bus.wave_we) begin
                if (nw < 2048) begin
                    seq_idx[nw] = int'(bus.wave_index);
                    seq_val[nw] = int'(bus.wave_prof);
                end
                nw++;
            end
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
    endtask

    task automatic check_fill(input string name, input int exp_done);
        check({name, " writes"}, nw, DEPTH);
        check({name, " done_cycle"}, done_at, exp_done);
        step();
        check({name, " done_width"}, int'(bus.done), 0);
    endtask

    initial begin
        int  bad;
        logic same;

        // mode, level, amp, period_log2, write position, expected value
        add(0, 900,   0,  0,    0, 767);
        add(0, 900,   0,  0, 1023, 767);
        add(1,   0,   1,  0,    5,   5);
        add(1,   0,   1,  0,  766, 766);
        add(1,   0,   1,  0,  767, 767);
        add(1,   0,   1,  0, 1023, 767);
        add(1, 700,   3,  0,    0, 700);
        add(1, 700,   3,  0,   22, 766);
        add(1, 700,   3,  0,   23, 767);
        add(3, 100,  50,  3,    0, 100);
        add(3, 100,  50,  3,    7, 100);
        add(3, 100,  50,  3,    8, 150);
        add(3, 100,  50,  3,   15, 150);
        add(3, 100,  50,  3,   16, 100);
        add(3, 100,  50,  3, 1023, 150);
        add(3, 100, 700,  3,    0, 100);
        add(3, 100, 700,  3,    8, 767);
        add(2,  10,   3,  2,    4,  22);
        add(2,  10,   3,  2,    5,  19);
        add(2,  10,   3,  2,    8,  10);
        add(2,  10,   3,  2,    9,  13);
        add(2, 700,  50,  2,    2, 767);
        add(2, 700,  50,  2,    4, 767);
        add(2, 700,  50,  2,    5, 717);
        add(2, 700,  50,  2,    8, 567);
        add(2, 700, 400,  1,    3, 367);
        add(2, 700, 400,  1,    4,   0);
        add(2, 700, 400,  1,    5, 400);
        add(2, 700, 400,  1,    6, 767);
        add(3,   5,  10, 12,  511,   5);
        add(3,   5,  10, 12,  512,  15);
        add(3,   5,  10, 12, 1023,  15);

        reset           = 1'b1;
        bus.mode        = 2'd0;
        bus.level       = VAL_W'(384);
        bus.amp         = '0;
        bus.period_log2 = '0;
        bus.start       = 1'b0;
`ifdef WAVE_PROF_SCROLL_EN
        bus.scroll      = '0;
`endif
        #12;
        check("reset wave_we", int'(bus.wave_we), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset wave_index", int'(bus.wave_index), 0);
        check("reset wave_prof", int'(bus.wave_prof), 0);
        #1;
        reset = 1'b0;

        // Automatic fill after release: trigger on the first edge, done on edge DEPTH+2
        run_capture(1100);
        check_fill("reset_fill", 1026);
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (seq_idx[k] != k || seq_val[k] != 384) bad++;
        check("reset_fill bad_entries", bad, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            same = 1'b0;
            if (i > 0)
                same = (vecs[i].mode == vecs[i-1].mode) && (vecs[i].level == vecs[i-1].level) &&
                       (vecs[i].amp == vecs[i-1].amp) && (vecs[i].period == vecs[i-1].period);
            if (!same) begin
                launch(vecs[i].mode, vecs[i].level, vecs[i].amp, vecs[i].period);
                run_capture(1100);
                check_fill($sformatf("fill_v%0d", i), 1025);
            end
            check($sformatf("v%0d index", i), seq_idx[vecs[i].pos], vecs[i].pos);
            check($sformatf("v%0d value", i), seq_val[vecs[i].pos], vecs[i].exp_val);
        end

        // Mode change mid-fill aborts and restarts from entry 0 with newly captured parameters
        launch(0, 50, 5, 2);
        for (int c = 1; c <= 500; c++) step();
        bus.mode  = 2'd2;
        bus.level = VAL_W'(60);
        step();
        check("abort last_old index", int'(bus.wave_index), 500);
        check("abort last_old value", int'(bus.wave_prof), 50);
        step();
        check("abort restart index", int'(bus.wave_index), 0);
        check("abort restart value", int'(bus.wave_prof), 60);
        check("abort restart we", int'(bus.wave_we), 1);
        run_capture(1100);
        check("abort remaining writes", nw, 1023);
        check("abort done_cycle", done_at, 1024);
        check("abort entry1 value", seq_val[0], 65);

        // Start on the final-write edge: no gap, no done, busy stays high
        launch(0, 20, 0, 0);
        for (int c = 1; c <= 1023; c++) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("edge_restart last index", int'(bus.wave_index), 1023);
        step();
        check("edge_restart index", int'(bus.wave_index), 0);
        check("edge_restart busy", int'(bus.busy), 1);
        check("edge_restart done", int'(bus.done), 0);
        run_capture(1100);
        check("edge_restart remaining writes", nw, 1023);
        check("edge_restart done_cycle", done_at, 1024);

        // Held start keeps rewriting entry 0
        bus.level = VAL_W'(30);
        bus.start = 1'b1;
        step();
        step();
        step();
        check("held_start index", int'(bus.wave_index), 0);
        check("held_start we", int'(bus.wave_we), 1);
        bus.start = 1'b0;
        run_capture(1100);
        check_fill("held_start", 1025);
        check("held_start entry0 value", seq_val[0], 30);

        // Reset mid-fill drops the write port at once, then the auto fill restarts
        launch(1, 0, 1, 0);
        for (int c = 1; c <= 100; c++) step();
        #2;
        reset = 1'b1;
        #1;
        check("midreset we", int'(bus.wave_we), 0);
        check("midreset busy", int'(bus.busy), 0);
        #3;
        reset = 1'b0;
        run_capture(1100);
        check_fill("midreset_refill", 1026);
        check("midreset entry0 index", seq_idx[0], 0);
        check("midreset entry10 value", seq_val[10], 10);

`ifdef WAVE_PROF_SCROLL_EN
        bus.scroll = IDX_W'(1020);
        launch(1, 0, 1, 0);
        run_capture(1100);
        check_fill("scroll", 1025);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("scroll w%0d index", k), seq_idx[k], (1020 + k) % 1024);
            check($sformatf("scroll w%0d value", k), seq_val[k], k);
        end
        bus.scroll = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
